pc_gen: RTL

Parametrised next-generation program-counter generator for the MIPS fetch stage. It drives the instruction-ROM address and chip-enable, and adds several behaviours the first-generation PC register lacks:
- configurable reset vector
- pipeline stall
- exception/flush redirect
- branch redirect
- a one-entry buffer that holds a branch arriving during a stall
- misalignment flagging

It sits between the control unit (stall/flush), ID stage (branch) and instruction ROM.

---
 rtl/pc_gen_pkg.sv | 17 +
 rtl/pc_redirect_buf.sv | 32 +++
 rtl/pc_gen.sv | 91 +++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared constants and state type for the fetch-stage PC generator
package pc_gen_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int          InstAddrW   = 32;
  localparam logic [31:0] DefResetVec = 32'h0000_0000;
  localparam int          InstBytes   = 4;

  typedef enum logic {
    PC_OFF = 1'b0,
    PC_RUN = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - one-entry buffer holding a branch target that arrived during a stall
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int W = InstAddrW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         consume,
  input  logic         clear,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      // newest branch wins; an older buffered target is simply overwritten
      valid <= 1'b1;
      data  <= load_data;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with stall, flush, branch and buffered-branch redirect
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = InstAddrW,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DefResetVec),
  parameter int                INST_BYTES = InstBytes
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              branch_pending,
  output logic              addr_err
);

  localparam int ALIGN = $clog2(INST_BYTES);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pend_tgt;
  logic              buf_load, buf_consume, buf_clear;

  pc_redirect_buf #(.W(ADDR_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (branch_target),
    .consume   (buf_consume),
    .clear     (buf_clear),
    .valid     (branch_pending),
    .data      (pend_tgt)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= PC_OFF;
      ce      <= ChipDisable;
      pc      <= RESET_VEC;
    end else begin
      state_q <= state_d;
      ce      <= (state_d == PC_RUN) ? ChipEnable : ChipDisable;
      pc      <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    buf_load    = 1'b0;
    buf_consume = 1'b0;
    buf_clear   = 1'b0;
    case (state_q)
      PC_OFF: begin
        // first fetch is RESET_VEC itself, so pc is left untouched here
        state_d = PC_RUN;
      end
      PC_RUN: begin
        if (flush) begin
          pc_d      = flush_pc;
          buf_clear = 1'b1;
        end else if (stall) begin
          buf_load = branch_valid;
        end else if (branch_valid) begin
          pc_d      = branch_target;
          buf_clear = 1'b1;
        end else if (branch_pending) begin
          pc_d        = pend_tgt;
          buf_consume = 1'b1;
        end else begin
          pc_d = pc + ADDR_W'(INST_BYTES);
        end
      end
      default: state_d = PC_OFF;
    endcase
  end

  generate
    if (ALIGN == 0) begin : g_no_align
      assign addr_err = 1'b0;
    end else begin : g_align
      assign addr_err = ce & (|pc[ALIGN-1:0]);
    end
  endgenerate

endmodule
